mem_access_unit: RTL

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/riscv_pkg.sv | 29 ++
 rtl/mem_access_unit_if.sv | 25 ++
 rtl/mem_access_unit_lsu_align.sv | 67 ++++++
 rtl/mem_access_unit.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared encodings for the memory stage.
//   load_type_e  : 3-bit load width/sign selector (LD_NONE = no load)
//   store_type_e : 2-bit store width selector (ST_NONE = no store)
//   mau_state_e  : memory access unit FSM states
package riscv_pkg;

    typedef enum logic [2:0] {
        LD_LB   = 3'b000,
        LD_LH   = 3'b001,
        LD_LW   = 3'b010,
        LD_LBU  = 3'b100,
        LD_LHU  = 3'b101,
        LD_NONE = 3'b111
    } load_type_e;

    typedef enum logic [1:0] {
        ST_SB   = 2'b00,
        ST_SH   = 2'b01,
        ST_SW   = 2'b10,
        ST_NONE = 2'b11
    } store_type_e;

    typedef enum logic [1:0] {
        MAU_IDLE     = 2'b00,
        MAU_REQ      = 2'b01,
        MAU_WAIT_RSP = 2'b10
    } mau_state_e;

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-memory request/response bus.
//   dmem_req_valid/dmem_req_ready : request handshake
//   dmem_addr/we/be/wdata         : word-aligned request payload
//   dmem_rsp_valid/dmem_rdata     : read response (no backpressure)
// master = memory access unit, slave = memory.
interface mem_access_unit_if;
    logic        dmem_req_valid;
    logic        dmem_req_ready;
    logic [31:0] dmem_addr;
    logic        dmem_we;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_rsp_valid;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req_valid, dmem_addr, dmem_we, dmem_be, dmem_wdata,
        input  dmem_req_ready, dmem_rsp_valid, dmem_rdata
    );

    modport slave (
        input  dmem_req_valid, dmem_addr, dmem_we, dmem_be, dmem_wdata,
        output dmem_req_ready, dmem_rsp_valid, dmem_rdata
    );
endinterface

// File: rtl/mem_access_unit_lsu_align.sv
// lsu_align: combinational alignment helper for the memory stage.
//   addr_i        : effective byte address
//   store_data_i  : raw store operand
//   rdata_i       : word returned by memory
//   is_load_i     : access is a load (else store)
//   load_type_i / store_type_i : access width/sign
//   misaligned_o  : access crosses its natural alignment
//   be_o, wdata_o : byte enables and lane-replicated store data
//   load_data_o   : extracted, sign/zero-extended load result
module lsu_align
    import riscv_pkg::*;
(
    input  logic [31:0] addr_i,
    input  logic [31:0] store_data_i,
    input  logic [31:0] rdata_i,
    input  logic        is_load_i,
    input  load_type_e  load_type_i,
    input  store_type_e store_type_i,
    output logic        misaligned_o,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] load_data_o
);

    // Bring the addressed byte/halfword down to bit 0.
    logic [31:0] rdata_shifted;
    assign rdata_shifted = rdata_i >> {addr_i[1:0], 3'b000};

    always_comb begin
        misaligned_o = 1'b0;
        be_o         = 4'b1111;
        wdata_o      = store_data_i;
        if (is_load_i) begin
            case (load_type_i)
                LD_LH, LD_LHU: misaligned_o = addr_i[0];
                LD_LW:         misaligned_o = |addr_i[1:0];
                default:       misaligned_o = 1'b0;
            endcase
        end else begin
            case (store_type_i)
                ST_SB: begin
                    be_o    = 4'b0001 << addr_i[1:0];
                    wdata_o = {4{store_data_i[7:0]}};
                end
                ST_SH: begin
                    be_o         = 4'b0011 << addr_i[1:0];
                    wdata_o      = {2{store_data_i[15:0]}};
                    misaligned_o = addr_i[0];
                end
                ST_SW:   misaligned_o = |addr_i[1:0];
                default: misaligned_o = 1'b0;
            endcase
        end
    end

    always_comb begin
        load_data_o = rdata_i;
        case (load_type_i)
            LD_LB:   load_data_o = {{24{rdata_shifted[7]}}, rdata_shifted[7:0]};
            LD_LH:   load_data_o = {{16{rdata_shifted[15]}}, rdata_shifted[15:0]};
            LD_LBU:  load_data_o = {24'h0, rdata_shifted[7:0]};
            LD_LHU:  load_data_o = {16'h0, rdata_shifted[15:0]};
            default: load_data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM stage. Issues loads/stores on the dmem bus, stalls
// the pipeline while an access is outstanding and registers the MEM/WB
// result.
//   clk, rst                : clock, synchronous active-high reset
//   mem_result              : ALU result / effective address
//   mem_op2_selected        : store data
//   mem_memory_write        : store request
//   mem_memory_load_type    : load selector (111 = none)
//   mem_memory_store_type   : store selector (11 = none)
//   mem_wb_load/_reg_file/_rd : WB result select, write enable, dest reg
//   dmem                    : data-memory bus (master side)
//   mem_stall               : access in flight and not finishing this cycle
//   wb_result/wb_reg_file/wb_rd : registered MEM/WB outputs
//   misalign_exc            : one-cycle misalignment flag
// Inputs are assumed held by the stalled pipeline while mem_stall is high,
// so the request payload is driven straight from them.
module mem_access_unit
    import riscv_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] mem_result,
    input  logic [31:0] mem_op2_selected,
    input  logic        mem_memory_write,
    input  logic [2:0]  mem_memory_load_type,
    input  logic [1:0]  mem_memory_store_type,
    input  logic        mem_wb_load,
    input  logic        mem_wb_reg_file,
    input  logic [4:0]  mem_wb_rd,
    mem_access_unit_if.master dmem,
    output logic        mem_stall,
    output logic [31:0] wb_result,
    output logic        wb_reg_file,
    output logic [4:0]  wb_rd,
    output logic        misalign_exc
);

    mau_state_e  state_q, state_d;
    logic [31:0] wb_result_q;
    logic        wb_reg_file_q;
    logic [4:0]  wb_rd_q;
    logic        misalign_exc_q;

    load_type_e  load_type;
    store_type_e store_type;
    logic        is_load, is_store, mem_op;
    logic        misaligned, misalign_now;
    logic        req_valid, complete;
    logic [3:0]  be;
    logic [31:0] wdata, load_data;

    assign load_type  = load_type_e'(mem_memory_load_type);
    assign store_type = store_type_e'(mem_memory_store_type);
    assign is_load    = (load_type != LD_NONE);
    assign is_store   = mem_memory_write && (store_type != ST_NONE);
    assign mem_op     = is_load || is_store;

    lsu_align u_align (
        .addr_i       (mem_result),
        .store_data_i (mem_op2_selected),
        .rdata_i      (dmem.dmem_rdata),
        .is_load_i    (is_load),
        .load_type_i  (load_type),
        .store_type_i (store_type),
        .misaligned_o (misaligned),
        .be_o         (be),
        .wdata_o      (wdata),
        .load_data_o  (load_data)
    );

    // A misaligned op is dropped in IDLE: no request, just a flag and a bubble.
    assign misalign_now = (state_q == MAU_IDLE) && mem_op && misaligned;

    always_comb begin
        state_d   = state_q;
        req_valid = 1'b0;
        complete  = 1'b0;
        case (state_q)
            MAU_IDLE: begin
                if (mem_op && !misaligned) begin
                    req_valid = 1'b1;
                    if (dmem.dmem_req_ready) begin
                        if (is_load) state_d  = MAU_WAIT_RSP;
                        else         complete = 1'b1;
                    end else begin
                        state_d = MAU_REQ;
                    end
                end
            end
            MAU_REQ: begin
                req_valid = 1'b1;
                if (dmem.dmem_req_ready) begin
                    if (is_load) begin
                        state_d = MAU_WAIT_RSP;
                    end else begin
                        complete = 1'b1;
                        state_d  = MAU_IDLE;
                    end
                end
            end
            MAU_WAIT_RSP: begin
                if (dmem.dmem_rsp_valid) begin
                    complete = 1'b1;
                    state_d  = MAU_IDLE;
                end
            end
            default: state_d = MAU_IDLE;
        endcase
    end

    // Outside IDLE an access is always in flight; in IDLE only an aligned op.
    assign mem_stall = ((state_q != MAU_IDLE) || (mem_op && !misaligned)) && !complete;

    assign dmem.dmem_req_valid = req_valid && !rst;
    assign dmem.dmem_addr      = {mem_result[31:2], 2'b00};
    assign dmem.dmem_we        = !is_load && is_store;
    assign dmem.dmem_be        = be;
    assign dmem.dmem_wdata     = wdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= MAU_IDLE;
            wb_result_q    <= 32'h0;
            wb_reg_file_q  <= 1'b0;
            wb_rd_q        <= 5'd0;
            misalign_exc_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            misalign_exc_q <= misalign_now;
            if (mem_stall || misalign_now) begin
                // Bubble into WB; the last result is kept.
                wb_reg_file_q <= 1'b0;
                wb_rd_q       <= 5'd0;
            end else begin
                wb_result_q   <= mem_wb_load ? load_data : mem_result;
                wb_reg_file_q <= mem_wb_reg_file;
                wb_rd_q       <= mem_wb_rd;
            end
        end
    end

    assign wb_result    = wb_result_q;
    assign wb_reg_file  = wb_reg_file_q;
    assign wb_rd        = wb_rd_q;
    assign misalign_exc = misalign_exc_q;

endmodule
